flash_line_reader: RTL



---
 rtl/flash_line_reader_if.sv | 33 +++
 rtl/flash_line_reader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/flash_line_reader_if.sv
//------------------------------------------------------------------------------
// flash_line_reader_if : request/response and quad-SPI pin bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface flash_line_reader_if #(
  parameter int LINE_SIZE = 128
);
  logic [23:0]          addr;
  logic                 rd;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [LINE_SIZE-1:0] line;
  logic                 sck;
  logic                 ce_n;
  logic [3:0]           din;
  logic [3:0]           dout;
  logic                 douten;

  modport master (
    output addr, rd, flush, din,
    input  busy, done, line, sck, ce_n, dout, douten
  );

  modport slave (
    input  addr, rd, flush, din,
    output busy, done, line, sck, ce_n, dout, douten
  );
endinterface

`default_nettype wire

// File: rtl/flash_line_reader.sv
//------------------------------------------------------------------------------
// flash_line_reader : quad-I/O (0xEB) SPI flash cache-line fetcher with XIP
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module flash_line_reader #(
  parameter int LINE_SIZE    = 128,
  parameter int DUMMY_CYCLES = 4,
  parameter int CONT_READ    = 0
) (
  input wire                 clk,
  input wire                 rst_n,
  flash_line_reader_if.slave bus
);
  localparam int          c_NIBS  = LINE_SIZE / 4;
  localparam int          c_ABITS = $clog2(LINE_SIZE / 8);
  localparam int          c_IW    = $clog2(LINE_SIZE);
  localparam logic [7:0]  c_CMD   = 8'hEB;
  localparam logic [7:0]  c_MODE  = (CONT_READ != 0) ? 8'hA0 : 8'hFF;
  localparam logic [23:0] c_AMASK = ~((24'd1 << c_ABITS) - 24'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_EXIT
  } state_t;

  state_t               r_state;
  logic [6:0]           r_cnt;
  logic [23:0]          r_addr;
  logic [LINE_SIZE-1:0] r_buf;
  logic [LINE_SIZE-1:0] r_line;
  logic                 r_cont;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_sck;
  logic                 r_ce_n;
  logic [3:0]           r_dout;
  logic                 r_douten;

  state_t               w_nstate;
  logic [6:0]           w_ncnt;
  logic [6:0]           w_len_m1;
  logic [23:0]          w_addr_in;
  logic [c_IW-1:0]      w_idx;
  logic [LINE_SIZE-1:0] w_buf_nxt;

  // Nibble presented on IO0..IO3 during sck cycle c of phase st.
  function automatic logic [3:0] f_nib(state_t st, logic [2:0] c, logic [23:0] a);
    logic [23:0] sh;
    sh    = a << {c, 2'b00};
    f_nib = 4'h0;
    case (st)
      S_CMD:   f_nib = {3'b000, c_CMD[3'd7 - c]};
      S_ADDR:  f_nib = sh[23:20];
      S_MODE:  f_nib = c[0] ? c_MODE[3:0] : c_MODE[7:4];
      S_EXIT:  f_nib = 4'hF;
      default: f_nib = 4'h0;
    endcase
  endfunction

  function automatic logic f_oe(state_t st);
    return (st == S_CMD) || (st == S_ADDR) || (st == S_MODE) || (st == S_EXIT);
  endfunction

  assign w_addr_in = bus.addr & c_AMASK;

  always_comb begin
    w_len_m1 = 7'd7;
    case (r_state)
      S_ADDR:  w_len_m1 = 7'd5;
      S_MODE:  w_len_m1 = 7'd1;
      S_DUMMY: w_len_m1 = 7'(DUMMY_CYCLES - 1);
      S_DATA:  w_len_m1 = 7'(c_NIBS - 1);
      default: w_len_m1 = 7'd7;
    endcase
    w_nstate = r_state;
    w_ncnt   = r_cnt + 7'd1;
    if (r_cnt == w_len_m1) begin
      w_ncnt = 7'd0;
      case (r_state)
        S_CMD:   w_nstate = S_ADDR;
        S_ADDR:  w_nstate = S_MODE;
        S_MODE:  w_nstate = S_DUMMY;
        S_DUMMY: w_nstate = S_DATA;
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  // Nibble i of the stream lands in slot i^1: high nibble first within each byte.
  always_comb begin
    w_idx     = c_IW'({r_cnt ^ 7'd1, 2'b00});
    w_buf_nxt = r_buf;
    w_buf_nxt[w_idx +: 4] = bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 7'd0;
      r_addr   <= 24'd0;
      r_buf    <= '0;
      r_line   <= '0;
      r_cont   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sck    <= 1'b0;
      r_ce_n   <= 1'b1;
      r_dout   <= 4'h0;
      r_douten <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.flush) begin
            r_state  <= S_EXIT;
            r_cnt    <= 7'd0;
            r_busy   <= 1'b1;
            r_ce_n   <= 1'b0;
            r_dout   <= 4'hF;
            r_douten <= 1'b1;
          end else if (bus.rd) begin
            r_addr   <= w_addr_in;
            r_state  <= r_cont ? S_ADDR : S_CMD;
            r_cnt    <= 7'd0;
            r_busy   <= 1'b1;
            r_ce_n   <= 1'b0;
            r_dout   <= f_nib(r_cont ? S_ADDR : S_CMD, 3'd0, w_addr_in);
            r_douten <= 1'b1;
          end
        end
        default: begin
          r_sck <= ~r_sck;
          // Everything advances on sck falling so the flash sees stable data on rising.
          if (r_sck) begin
            r_state  <= w_nstate;
            r_cnt    <= w_ncnt;
            r_dout   <= f_nib(w_nstate, w_ncnt[2:0], r_addr);
            r_douten <= f_oe(w_nstate);
            if (r_state == S_DATA) begin
              r_buf <= w_buf_nxt;
            end
            if (w_nstate == S_IDLE) begin
              r_busy <= 1'b0;
              r_ce_n <= 1'b1;
              r_sck  <= 1'b0;
              if (r_state == S_DATA) begin
                r_done <= 1'b1;
                r_line <= w_buf_nxt;
                if (CONT_READ != 0) begin
                  r_cont <= 1'b1;
                end
              end else begin
                r_cont <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.line   = r_line;
  assign bus.sck    = r_sck;
  assign bus.ce_n   = r_ce_n;
  assign bus.dout   = r_dout;
  assign bus.douten = r_douten;
endmodule

`default_nettype wire
